// File: rtl/ddr3_cmd_decoder.sv
// DDR3 command-bus decoder: decodes pin-level commands, tracks bank/mode state
// and per-bank/global timing windows, and reports the highest-priority protocol violation.
module ddr3_cmd_decoder #(
    parameter int unsigned BA_BITS   = 3,
    parameter int unsigned ADDR_BITS = 14,
    parameter int unsigned T_RCD     = 6,
    parameter int unsigned T_RP      = 6,
    parameter int unsigned T_MRD     = 4,
    parameter int unsigned T_RFC     = 44
) (
    input  logic                        ck,
    input  logic                        rst,
    input  logic                        cke,
    input  logic                        cs_n,
    input  logic                        ras_n,
    input  logic                        cas_n,
    input  logic                        we_n,
    input  logic [BA_BITS-1:0]          ba,
    input  logic [ADDR_BITS-1:0]        addr,
    output logic                        cmd_valid,
    output logic [2:0]                  cmd_code,
    output logic [BA_BITS-1:0]          cmd_ba,
    output logic [ADDR_BITS-1:0]        cmd_addr,
    output logic [ADDR_BITS-1:0]        mr0,
    output logic [ADDR_BITS-1:0]        mr1,
    output logic [ADDR_BITS-1:0]        mr2,
    output logic [(1 << BA_BITS)-1:0]   bank_open,
    output logic                        err_valid,
    output logic [2:0]                  err_code,
    output logic [BA_BITS-1:0]          err_ba,
    output logic [15:0]                 ref_count
);

    localparam int unsigned NB     = 1 << BA_BITS;
    localparam int unsigned T_MAX0 = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int unsigned T_MAX1 = (T_MRD > T_RFC) ? T_MRD : T_RFC;
    localparam int unsigned T_MAX  = (T_MAX0 > T_MAX1) ? T_MAX0 : T_MAX1;
    localparam int unsigned CNT_W  = (T_MAX > 2) ? $clog2(T_MAX) : 1;

    // Counters hold the cycles still blocked *after* the next edge, so a
    // command exactly T cycles after its trigger sees zero.
    localparam logic [CNT_W-1:0] LD_RCD = (T_RCD == 0) ? '0 : CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] LD_RP  = (T_RP  == 0) ? '0 : CNT_W'(T_RP  - 1);
    localparam logic [CNT_W-1:0] LD_MRD = (T_MRD == 0) ? '0 : CNT_W'(T_MRD - 1);
    localparam logic [CNT_W-1:0] LD_RFC = (T_RFC == 0) ? '0 : CNT_W'(T_RFC - 1);

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_MRS = 3'd1;
    localparam logic [2:0] C_REF = 3'd2;
    localparam logic [2:0] C_PRE = 3'd3;
    localparam logic [2:0] C_ACT = 3'd4;
    localparam logic [2:0] C_WR  = 3'd5;
    localparam logic [2:0] C_RD  = 3'd6;
    localparam logic [2:0] C_ZQ  = 3'd7;

    logic [CNT_W-1:0] r_rcd [NB];
    logic [CNT_W-1:0] r_rp  [NB];
    logic [CNT_W-1:0] r_mrd;
    logic [CNT_W-1:0] r_rfc;

    logic       w_cmd;
    logic [2:0] w_code;
    logic       w_is_rw;
    logic       w_ap;
    logic       w_open;
    logic [2:0] w_err_code;

    // Pin decode; deselect and power-down map to NOP
    always_comb begin
        w_code = C_NOP;
        if (cke && !cs_n) begin
            case ({ras_n, cas_n, we_n})
                3'b000:  w_code = C_MRS;
                3'b001:  w_code = C_REF;
                3'b010:  w_code = C_PRE;
                3'b011:  w_code = C_ACT;
                3'b100:  w_code = C_WR;
                3'b101:  w_code = C_RD;
                3'b110:  w_code = C_ZQ;
                default: w_code = C_NOP;
            endcase
        end
    end

    assign w_cmd   = (w_code != C_NOP);
    assign w_is_rw = (w_code == C_RD) || (w_code == C_WR);
    assign w_ap    = addr[10];
    assign w_open  = bank_open[ba];

    // Violation check against pre-command state, highest priority first
    always_comb begin
        w_err_code = 3'd0;
        if (w_cmd) begin
            if (r_rfc != '0)
                w_err_code = 3'd6;
            else if (r_mrd != '0)
                w_err_code = 3'd5;
            else if (((w_code == C_REF) || (w_code == C_MRS)) && (bank_open != '0))
                w_err_code = 3'd7;
            else if ((w_code == C_ACT) && (r_rp[ba] != '0))
                w_err_code = 3'd4;
            else if ((w_code == C_ACT) && w_open)
                w_err_code = 3'd1;
            else if (w_is_rw && !w_open)
                w_err_code = 3'd2;
            else if (w_is_rw && (r_rcd[ba] != '0))
                w_err_code = 3'd3;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            cmd_ba    <= '0;
            cmd_addr  <= '0;
            err_valid <= 1'b0;
            err_code  <= '0;
            err_ba    <= '0;
            mr0       <= '0;
            mr1       <= '0;
            mr2       <= '0;
            bank_open <= '0;
            ref_count <= '0;
            r_mrd     <= '0;
            r_rfc     <= '0;
            for (int i = 0; i < NB; i++) begin
                r_rcd[i] <= '0;
                r_rp[i]  <= '0;
            end
        end else begin
            cmd_valid <= w_cmd;
            err_valid <= (w_err_code != 3'd0);
            if (w_cmd) begin
                cmd_code <= w_code;
                cmd_ba   <= ba;
                cmd_addr <= addr;
            end
            if (w_err_code != 3'd0) begin
                err_code <= w_err_code;
                err_ba   <= ba;
            end

            r_mrd <= (r_mrd != '0) ? r_mrd - CNT_W'(1) : '0;
            r_rfc <= (r_rfc != '0) ? r_rfc - CNT_W'(1) : '0;
            for (int i = 0; i < NB; i++) begin
                r_rcd[i] <= (r_rcd[i] != '0) ? r_rcd[i] - CNT_W'(1) : '0;
                r_rp[i]  <= (r_rp[i]  != '0) ? r_rp[i]  - CNT_W'(1) : '0;
            end

            // State updates apply even when the command is flagged
            case (w_code)
                C_MRS: begin
                    r_mrd <= LD_MRD;
                    if (ba == BA_BITS'(0))      mr0 <= addr;
                    else if (ba == BA_BITS'(1)) mr1 <= addr;
                    else if (ba == BA_BITS'(2)) mr2 <= addr;
                end
                C_REF: begin
                    r_rfc     <= LD_RFC;
                    ref_count <= ref_count + 16'd1;
                end
                C_ACT: begin
                    bank_open[ba] <= 1'b1;
                    r_rcd[ba]     <= LD_RCD;
                end
                C_PRE: begin
                    if (w_ap) begin
                        bank_open <= '0;
                        for (int i = 0; i < NB; i++) r_rp[i] <= LD_RP;
                    end else begin
                        bank_open[ba] <= 1'b0;
                        r_rp[ba]      <= LD_RP;
                    end
                end
                C_WR, C_RD: begin
                    if (w_ap) begin
                        bank_open[ba] <= 1'b0;
                        r_rp[ba]      <= LD_RP;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_cmd_decoder.sv
// Scoreboard bench for ddr3_cmd_decoder: directed protocol scenarios plus random
// traffic, checked against a timestamp-based reference model.
module tb_ddr3_cmd_decoder;

    localparam int unsigned NB    = 8;
    localparam longint      T_RCD = 6;
    localparam longint      T_RP  = 6;
    localparam longint      T_MRD = 4;
    localparam longint      T_RFC = 44;
    localparam longint      LONG_AGO = -1000;

    localparam logic [2:0] P_MRS = 3'b000;
    localparam logic [2:0] P_REF = 3'b001;
    localparam logic [2:0] P_PRE = 3'b010;
    localparam logic [2:0] P_ACT = 3'b011;
    localparam logic [2:0] P_WR  = 3'b100;
    localparam logic [2:0] P_RD  = 3'b101;
    localparam logic [2:0] P_NOP = 3'b111;

    logic        ck = 1'b0;
    logic        rst, cke, cs_n, ras_n, cas_n, we_n;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic        cmd_valid, err_valid;
    logic [2:0]  cmd_code, cmd_ba, err_code, err_ba;
    logic [13:0] cmd_addr, mr0, mr1, mr2;
    logic [7:0]  bank_open;
    logic [15:0] ref_count;

    ddr3_cmd_decoder dut (
        .ck(ck), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
        .we_n(we_n), .ba(ba), .addr(addr), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .cmd_ba(cmd_ba), .cmd_addr(cmd_addr), .mr0(mr0), .mr1(mr1), .mr2(mr2),
        .bank_open(bank_open), .err_valid(err_valid), .err_code(err_code),
        .err_ba(err_ba), .ref_count(ref_count)
    );

    always #5 ck = ~ck;

    typedef struct {
        bit          all;
        bit          cv;
        logic [2:0]  code;
        logic [2:0]  cba;
        logic [13:0] caddr;
        bit          ev;
        logic [2:0]  ecode;
        logic [2:0]  eba;
        logic [13:0] m0, m1, m2;
        logic [7:0]  open;
        logic [15:0] refc;
    } exp_t;

    exp_t   sb_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    // Reference model: absolute cycle stamps of the last triggering commands
    longint      cyc = 0;
    longint      t_act [NB];
    longint      t_pre [NB];
    longint      t_mrs, t_ref;
    logic [13:0] m_mr [3];
    logic [7:0]  m_open;
    logic [15:0] m_ref;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            t_act[i] = LONG_AGO;
            t_pre[i] = LONG_AGO;
        end
        t_mrs = LONG_AGO;
        t_ref = LONG_AGO;
        for (int i = 0; i < 3; i++) m_mr[i] = '0;
        m_open = '0;
        m_ref  = '0;
    endtask

    task automatic issue(input bit r, input bit k, input bit cs, input logic [2:0] pins,
                         input logic [2:0] b, input logic [13:0] a);
        exp_t   e;
        int     code;
        int     ec;
        bit     is_rw;
        bit     opn;
        @(negedge ck);
        rst = r; cke = k; cs_n = cs;
        {ras_n, cas_n, we_n} = pins;
        ba = b; addr = a;
        cyc++;
        e = '{all: 1'b0, cv: 1'b0, code: 3'd0, cba: 3'd0, caddr: 14'd0, ev: 1'b0,
              ecode: 3'd0, eba: 3'd0, m0: 14'd0, m1: 14'd0, m2: 14'd0, open: 8'd0, refc: 16'd0};
        if (r) begin
            model_reset();
            e.all = 1'b1;
        end else if (k && !cs && pins != P_NOP) begin
            code  = (pins == P_MRS) ? 1 : (pins == P_REF) ? 2 : (pins == P_PRE) ? 3 :
                    (pins == P_ACT) ? 4 : (pins == P_WR)  ? 5 : (pins == P_RD)  ? 6 : 7;
            is_rw = (code == 5) || (code == 6);
            opn   = m_open[b];
            ec = 0;
            if (cyc - t_ref < T_RFC)                             ec = 6;
            else if (cyc - t_mrs < T_MRD)                        ec = 5;
            else if ((code == 1 || code == 2) && m_open != 0)    ec = 7;
            else if (code == 4 && cyc - t_pre[b] < T_RP)         ec = 4;
            else if (code == 4 && opn)                           ec = 1;
            else if (is_rw && !opn)                              ec = 2;
            else if (is_rw && cyc - t_act[b] < T_RCD)            ec = 3;
            e.cv = 1'b1; e.code = 3'(code); e.cba = b; e.caddr = a;
            e.ev = (ec != 0); e.ecode = 3'(ec); e.eba = b;
            case (code)
                1: begin t_mrs = cyc; if (b < 3) m_mr[b] = a; end
                2: begin t_ref = cyc; m_ref = m_ref + 16'd1; end
                3: if (a[10]) begin
                       m_open = '0;
                       for (int i = 0; i < NB; i++) t_pre[i] = cyc;
                   end else begin
                       m_open[b] = 1'b0; t_pre[b] = cyc;
                   end
                4: begin m_open[b] = 1'b1; t_act[b] = cyc; end
                5, 6: if (a[10]) begin m_open[b] = 1'b0; t_pre[b] = cyc; end
                default: ;
            endcase
        end
        e.m0 = m_mr[0]; e.m1 = m_mr[1]; e.m2 = m_mr[2];
        e.open = m_open; e.refc = m_ref;
        sb_q.push_back(e);
    endtask

    task automatic cmd(input logic [2:0] pins, input logic [2:0] b, input logic [13:0] a);
        issue(1'b0, 1'b1, 1'b0, pins, b, a);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 1'b1, 1'b0, P_NOP, 3'd0, 14'd0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) issue(1'b1, 1'b1, 1'b0, P_MRS, 3'd0, 14'h3FFF);
    endtask

    // Monitor: every sampling edge yields one output set to score
    initial begin
        exp_t e;
        forever begin
            @(posedge ck);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.all || e.cv)
                    chk("cmd", 64'({cmd_valid, cmd_code, cmd_ba, cmd_addr}),
                               64'({e.cv, e.code, e.cba, e.caddr}));
                else
                    chk("cmd_valid", 64'(cmd_valid), 64'(e.cv));
                if (e.all || e.ev)
                    chk("err", 64'({err_valid, err_code, err_ba}), 64'({e.ev, e.ecode, e.eba}));
                else
                    chk("err_valid", 64'(err_valid), 64'(e.ev));
                chk("mode_regs", 64'({mr0, mr1, mr2}), 64'({e.m0, e.m1, e.m2}));
                chk("bank_ref", 64'({bank_open, ref_count}), 64'({e.open, e.refc}));
            end
        end
    end

    initial begin
        int r;
        int wait_cyc;
        rst = 1'b1; cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = P_NOP;
        ba = '0; addr = '0;
        model_reset();
        do_reset(2);

        // MRS load, then tMRD violation
        cmd(P_MRS, 3'd0, 14'h0120);
        nop(1);
        cmd(P_ACT, 3'd0, 14'h0000);
        cmd(P_PRE, 3'd0, 14'h0400);
        nop(8);

        // tRCD boundary
        cmd(P_ACT, 3'd2, 14'h1ABC);
        nop(5);
        cmd(P_RD, 3'd2, 14'h0010);
        cmd(P_PRE, 3'd0, 14'h0400);
        nop(6);
        cmd(P_ACT, 3'd2, 14'h1ABC);
        nop(2);
        cmd(P_RD, 3'd2, 14'h0010);
        cmd(P_PRE, 3'd0, 14'h0400);
        nop(6);

        // tRP boundary after precharge-all
        cmd(P_ACT, 3'd1, 14'h0055);
        cmd(P_PRE, 3'd0, 14'h0400);
        nop(2);
        cmd(P_ACT, 3'd1, 14'h0055);
        cmd(P_PRE, 3'd0, 14'h0400);
        nop(5);
        cmd(P_ACT, 3'd1, 14'h0055);
        cmd(P_PRE, 3'd1, 14'h0000);
        nop(6);

        // REF with open bank, then tRFC outranks closed-bank read
        cmd(P_ACT, 3'd3, 14'h0003);
        nop(6);
        cmd(P_REF, 3'd0, 14'h0000);
        cmd(P_PRE, 3'd0, 14'h0400);
        nop(50);
        cmd(P_REF, 3'd0, 14'h0000);
        nop(9);
        cmd(P_RD, 3'd0, 14'h0000);
        nop(50);

        // Auto-precharge write closes the bank
        cmd(P_ACT, 3'd4, 14'h0444);
        nop(5);
        cmd(P_WR, 3'd4, 14'h0400);
        nop(1);
        cmd(P_RD, 3'd4, 14'h0000);
        nop(6);

        // Ignored pins, MRS to ba>=3, and reset mid-tRFC
        issue(1'b0, 1'b1, 1'b1, P_MRS, 3'd1, 14'h2222);
        issue(1'b0, 1'b0, 1'b0, P_MRS, 3'd2, 14'h3333);
        cmd(P_MRS, 3'd1, 14'h0AAA);
        nop(4);
        cmd(P_MRS, 3'd5, 14'h1111);
        nop(4);
        cmd(P_REF, 3'd0, 14'h0000);
        nop(5);
        do_reset(1);
        cmd(P_ACT, 3'd5, 14'h0123);
        nop(2);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 1)       issue(1'b1, 1'b1, 1'b0, 3'($urandom), 3'($urandom), 14'($urandom));
            else if (r < 6)  issue(1'b0, 1'b1, 1'b1, 3'($urandom), 3'($urandom), 14'($urandom));
            else if (r < 10) issue(1'b0, 1'b0, 1'b0, 3'($urandom), 3'($urandom), 14'($urandom));
            else if (r < 55) nop(1);
            else             cmd(3'($urandom_range(0, 6)), 3'($urandom), 14'($urandom));
        end
        nop(2);

        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 20) begin
            @(posedge ck);
            wait_cyc++;
        end
        #2;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr3_cmd_decoder.md
DDR3_CMD_DECODER -- requirements
Module: ddr3_cmd_decoder

Interface
REQ-001 SHALL have parameter BA_BITS, default 3, bank address width (8 banks).
REQ-002 SHALL have parameter ADDR_BITS, default 14, address bus width; row address = addr[ADDR_BITS-1:0].
REQ-003 SHALL have parameters T_RCD 6, T_RP 6, T_MRD 4, T_RFC 44, minimum spacings in ck cycles.
REQ-004 SHALL provide ports: ck in 1, sole clock, all logic on rising edge.
REQ-005 SHALL provide: rst in 1, reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL provide: cke, cs_n, ras_n, cas_n, we_n in 1 each, DDR3 command pins sampled on posedge ck.
REQ-007 SHALL provide: ba in BA_BITS, addr in ADDR_BITS, command bank and address.
REQ-008 SHALL provide: cmd_valid out 1, cmd_code out 3, cmd_ba out BA_BITS, cmd_addr out ADDR_BITS, decoded command strobe and fields.
REQ-009 SHALL provide: mr0, mr1, mr2 out ADDR_BITS each, last loaded mode register values.
REQ-010 SHALL provide: bank_open out 2**BA_BITS, per-bank active flag.
REQ-011 SHALL provide: err_valid out 1, err_code out 3, err_ba out BA_BITS, protocol violation report.
REQ-012 SHALL provide: ref_count out 16, refresh commands accepted, wraps at 16'hFFFF to 0.

Function
REQ-013 SHALL sample inputs each posedge ck; all outputs registered, update exactly 1 cycle after the sampling edge.
REQ-014 SHALL ignore input (no command, no error, counters still run) when cke=0 or cs_n=1.
REQ-015 SHALL decode {ras_n,cas_n,we_n} with cs_n=0,cke=1: 000 MRS code 1, 001 REF code 2, 010 PRE code 3, 011 ACT code 4, 100 WR code 5, 101 RD code 6, 110 ZQ code 7, 111 NOP code 0.
REQ-016 SHALL pulse cmd_valid 1 cycle for every decoded non-NOP command, with cmd_ba/cmd_addr copied from inputs; cmd_valid=0 for NOP/deselect.
REQ-017 SHALL on MRS with ba=0/1/2 load mr0/mr1/mr2 with addr; ba>=3 decoded but no register written.
REQ-018 SHALL on ACT set bank_open[ba] and start that bank's tRCD counter at T_RCD.
REQ-019 SHALL on PRE with addr[10]=1 clear all bank_open bits and start all banks' tRP counters; addr[10]=0 clears only bank ba.
REQ-020 SHALL on RD/WR with addr[10]=1 (auto-precharge) clear bank_open[ba] and start its tRP counter after the command.
REQ-021 SHALL on MRS start global tMRD counter at T_MRD; on REF start global tRFC counter at T_RFC and increment ref_count.
REQ-022 SHALL decrement every nonzero counter by 1 per cycle; constraint active while counter>0; restart on a new triggering command overwrites the value.
REQ-023 SHALL flag errors (err_valid 1 cycle, err_ba=ba): 1 ACT to open bank; 2 RD/WR to closed bank; 3 RD/WR while bank tRCD>0; 4 ACT while bank tRP>0; 5 non-NOP while tMRD>0; 6 non-NOP while tRFC>0; 7 REF or MRS with any bank open.
REQ-024 SHALL report only the highest-priority error when several apply, priority 6,5,7,4,1,2,3 (first highest).
REQ-025 SHALL still apply state updates (bank_open, mode regs, counters) of an erroneous command; cmd_valid also asserts.
REQ-026 SHALL check RD/WR tRCD against pre-command counter value, so RD/WR exactly T_RCD cycles after ACT is legal.

Reset
REQ-027 SHALL while rst=1 at posedge ck clear cmd_valid, cmd_code, cmd_ba, cmd_addr, err_valid, err_code, err_ba, mr0-mr2, bank_open, ref_count and all counters to 0.
REQ-028 SHALL ignore pin inputs during reset cycles; reset mid-sequence abandons all timing constraints.

Verification
REQ-029 SHALL cover: MRS ba=0 addr=14'h0120 -> next cycle cmd_valid=1, cmd_code=1, mr0=14'h0120; NOP 2 cycles later -> no error; ACT 2 cycles after MRS -> err_code=5.
REQ-030 SHALL cover: ACT ba=2 row 14'h1ABC, RD ba=2 at +6 cycles -> no error; RD at +3 -> err_code=3, err_ba=2.
REQ-031 SHALL cover: ACT ba=1, PRE addr[10]=1, ACT ba=1 after 3 cycles -> err_code=4; after 6 cycles -> clean, bank_open=8'h02.
REQ-032 SHALL cover: REF with bank 3 open -> err_code=7, ref_count=1; REF then RD at +10 cycles -> err_code=6 (priority over 2).
REQ-033 SHALL cover: WR ba=4 addr[10]=1 after legal ACT -> bank_open[4]=0; following RD ba=4 -> err_code=2.
REQ-034 SHALL cover: cs_n=1 or cke=0 with MRS pins -> no cmd_valid, mr regs unchanged; rst mid-tRFC -> all outputs 0, next ACT clean.
